// File: rtl/dsch_pkg.sv
// dsch_pkg: shared types, widths and parameter checks for the event responder slice
package dsch_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} dsch_state_e;
  localparam int DSCH_CNT_W = 8;
  function automatic bit dsch_params_ok(int unsigned delay, int unsigned rounds);
    return (delay >= 1) && (delay <= 255) && (rounds >= 1) && (rounds <= 255);
  endfunction
endpackage

// File: rtl/dsch_event_responder_if.sv
// dsch_event_responder_if: req/ack handshake bundle between initiator and responder
interface dsch_event_responder_if #(parameter int unsigned WIDTH = 32);
  logic             req_i;
  logic [WIDTH-1:0] value_o;
  logic             ack_o;
  logic             busy_o;
  logic             done_o;
  logic             overrun_o;
  logic [7:0]       round_o;
  modport master(output req_i, input value_o, ack_o, busy_o, done_o, overrun_o, round_o);
  modport slave(input req_i, output value_o, ack_o, busy_o, done_o, overrun_o, round_o);
endinterface

// File: rtl/dsch_delay_counter.sv
// dsch_delay_counter: loadable down-counter, zero_o marks the final counted cycle
module dsch_delay_counter
  import dsch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DSCH_CNT_W-1:0] load_val_i,
  output logic                  zero_o,
  output logic                  running_o
);
  logic [DSCH_CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      running_o <= 1'b0;
    end else if (load_i) begin
      cnt       <= load_val_i;
      running_o <= 1'b1;
    end else if (running_o) begin
      cnt       <= cnt - DSCH_CNT_W'(1);
      running_o <= cnt != '0;
    end
  assign zero_o = running_o && cnt == '0;
endmodule

// File: rtl/dsch_event_responder.sv
// dsch_event_responder: responder end of a req/ack event handshake, ROUNDS rounds then DONE
module dsch_event_responder
  import dsch_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      DELAY  = 1,
  parameter int unsigned      ROUNDS = 3,
  parameter logic [WIDTH-1:0] START  = WIDTH'(1),
  parameter logic [WIDTH-1:0] STEP   = WIDTH'(1)
) (
  input logic                     clk,
  input logic                     rst_n,
  dsch_event_responder_if.slave   bus
);
  if (!dsch_params_ok(DELAY, ROUNDS)) begin : g_bad_params
    $error("dsch_event_responder: DELAY and ROUNDS must lie in 1..255");
  end
  dsch_state_e state, state_n;
  logic accept, zero, running, last;
  assign accept = state == ST_IDLE && bus.req_i;
  assign last   = bus.round_o + 8'd1 == 8'(ROUNDS);
  dsch_delay_counter u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .load_val_i(DSCH_CNT_W'(DELAY - 1)),
    .zero_o    (zero),
    .running_o (running)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = ST_WAIT;
    else if (state == ST_WAIT && zero) state_n = last ? ST_DONE : ST_IDLE;
  end
  // a req landing while busy or done (including the ack cycle) is dropped and flagged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.value_o   <= '0;
      bus.round_o   <= '0;
      bus.overrun_o <= 1'b0;
    end else begin
      if (accept) bus.value_o <= bus.round_o == '0 ? START : bus.value_o + STEP;
      if (bus.ack_o) bus.round_o <= bus.round_o + 8'd1;
      if (bus.req_i && state != ST_IDLE) bus.overrun_o <= 1'b1;
    end
  assign bus.ack_o  = state == ST_WAIT && zero;
  assign bus.busy_o = running;
  assign bus.done_o = state == ST_DONE;
endmodule
